// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main controller.
// Holds state, opcode, funct, ALUOp and ALUControl codes used by the FSM and the ALU decoder.
// Optional feature macro: MIPS_CTRL_BNE_EN (adds the BNE state, encoding 12).
package mips_ctrl_pkg;

  localparam int unsigned OPCODE_W  = 6;
  localparam int unsigned FUNCT_W   = 6;
  localparam int unsigned ALUCTRL_W = 3;
  localparam int unsigned STATE_W   = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
`ifdef MIPS_CTRL_BNE_EN
    , S_BNE  = 4'd12
`endif
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [ALUCTRL_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALUCTRL_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALUCTRL_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALUCTRL_W-1:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_alu_decoder.sv
// ALU decoder: maps ALUOp and the R-type funct field onto the ALU operation select.
// Ports: i_aluop (add/sub/funct), i_funct (Instr[5:0]), o_alu_control (to the ALU).
module mips_alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned FUNCT_WIDTH      = 6,
  parameter int unsigned ALUControl_WIDTH = 3
) (
  input  aluop_t                      i_aluop,
  input  logic [FUNCT_WIDTH-1:0]      i_funct,
  output logic [ALUControl_WIDTH-1:0] o_alu_control
);

  // Unknown funct codes fall back to add so the datapath never sees an undefined op.
  always_comb begin
    o_alu_control = ALUControl_WIDTH'(ALU_ADD);
    case (i_aluop)
      ALUOP_ADD: o_alu_control = ALUControl_WIDTH'(ALU_ADD);
      ALUOP_SUB: o_alu_control = ALUControl_WIDTH'(ALU_SUB);
      ALUOP_FUNCT: begin
        case (i_funct)
          FUNCT_WIDTH'(FN_ADD): o_alu_control = ALUControl_WIDTH'(ALU_ADD);
          FUNCT_WIDTH'(FN_SUB): o_alu_control = ALUControl_WIDTH'(ALU_SUB);
          FUNCT_WIDTH'(FN_AND): o_alu_control = ALUControl_WIDTH'(ALU_AND);
          FUNCT_WIDTH'(FN_OR):  o_alu_control = ALUControl_WIDTH'(ALU_OR);
          FUNCT_WIDTH'(FN_SLT): o_alu_control = ALUControl_WIDTH'(ALU_SLT);
          default:              o_alu_control = ALUControl_WIDTH'(ALU_ADD);
        endcase
      end
      default: o_alu_control = ALUControl_WIDTH'(ALU_ADD);
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Main control FSM of the multicycle MIPS core (Moore outputs decoded from state).
// Inputs : clk, rst_n (async, active-low), opcode, funct, zero (ALU flag).
// Outputs: IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
//          ALUControl, PCSrc, PCEn, illegal_op, state_o (debug).
// Optional feature macro: MIPS_CTRL_BNE_EN (adds bne via state BNE = 12).
module mips_mc_controller
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_WIDTH     = 6,
  parameter int unsigned FUNCT_WIDTH      = 6,
  parameter int unsigned ALUControl_WIDTH = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [OPCODE_WIDTH-1:0]     opcode,
  input  logic [FUNCT_WIDTH-1:0]      funct,
  input  logic                        zero,
  output logic                        IorD,
  output logic                        MemWrite,
  output logic                        IRWrite,
  output logic                        RegDst,
  output logic                        MemtoReg,
  output logic                        RegWrite,
  output logic                        ALUSrcA,
  output logic [1:0]                  ALUSrcB,
  output logic [ALUControl_WIDTH-1:0] ALUControl,
  output logic [1:0]                  PCSrc,
  output logic                        PCEn,
  output logic                        illegal_op,
  output logic [3:0]                  state_o
);

  state_t r_state;
  state_t w_next;
  aluop_t w_aluop;
  logic   w_irwrite, w_memwrite, w_regwrite, w_pcwrite, w_branch, w_illegal, w_pcen;
`ifdef MIPS_CTRL_BNE_EN
  logic   w_branch_ne;
`endif

  // State register; async reset parks the FSM in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Next-state and per-state control decode.
  always_comb begin
    w_next     = S_FETCH;
    w_aluop    = ALUOP_ADD;
    w_irwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_illegal  = 1'b0;
`ifdef MIPS_CTRL_BNE_EN
    w_branch_ne = 1'b0;
`endif
    IorD     = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSrc    = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        ALUSrcB   = 2'b01;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        ALUSrcB = 2'b11;
        case (opcode)
          OPCODE_WIDTH'(OP_LW),
          OPCODE_WIDTH'(OP_SW):    w_next = S_MEMADR;
          OPCODE_WIDTH'(OP_RTYPE): w_next = S_EXEC;
          OPCODE_WIDTH'(OP_BEQ):   w_next = S_BEQ;
          OPCODE_WIDTH'(OP_ADDI):  w_next = S_ADDIEX;
          OPCODE_WIDTH'(OP_J):     w_next = S_JUMP;
`ifdef MIPS_CTRL_BNE_EN
          OPCODE_WIDTH'(OP_BNE):   w_next = S_BNE;
`endif
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = (opcode == OPCODE_WIDTH'(OP_LW)) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD   = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_regwrite = 1'b1;
        MemtoReg   = 1'b1;
      end
      S_MEMWR: begin
        IorD       = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        w_aluop = ALUOP_FUNCT;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA  = 1'b1;
        w_aluop  = ALUOP_SUB;
        w_branch = 1'b1;
        PCSrc    = 2'b01;
      end
`ifdef MIPS_CTRL_BNE_EN
      S_BNE: begin
        ALUSrcA     = 1'b1;
        w_aluop     = ALUOP_SUB;
        w_branch_ne = 1'b1;
        PCSrc       = 2'b01;
      end
`endif
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: w_regwrite = 1'b1;
      S_JUMP: begin
        PCSrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // The branch term is the only path from the zero input to an output.
`ifdef MIPS_CTRL_BNE_EN
  assign w_pcen = w_pcwrite | (w_branch & zero) | (w_branch_ne & ~zero);
`else
  assign w_pcen = w_pcwrite | (w_branch & zero);
`endif

  // Write enables are gated by rst_n so nothing commits while reset is held.
  assign IRWrite    = w_irwrite  & rst_n;
  assign MemWrite   = w_memwrite & rst_n;
  assign RegWrite   = w_regwrite & rst_n;
  assign PCEn       = w_pcen     & rst_n;
  assign illegal_op = w_illegal  & rst_n;
  assign state_o    = 4'(r_state);

  mips_alu_decoder #(
    .FUNCT_WIDTH      (FUNCT_WIDTH),
    .ALUControl_WIDTH (ALUControl_WIDTH)
  ) u_alu_decoder (
    .i_aluop       (w_aluop),
    .i_funct       (funct),
    .o_alu_control (ALUControl)
  );

endmodule
